as2650_extbus_ctrl: RTL

//  Sequences AS2650 external memory/IO cycles onto a shared 8-bit multiplexed pad bus
//  (address high, address low, then data) inside wrapped_as2650.

---
 rtl/as2650_pkg.sv | 15 +
 rtl/as2650_wait_counter.sv | 51 +++++
 rtl/as2650_extbus_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/as2650_pkg.sv
// Shared types and pad-enable constants for the AS2650 external bus sequencer.
package as2650_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR_H = 3'd1,
        ADDR_L = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic [7:0] OEB_DRIVE = 8'h00;
    localparam logic [7:0] OEB_FLOAT = 8'hFF;

endpackage

// File: rtl/as2650_wait_counter.sv
// Strobe length control: a loadable down-counter for the fixed wait states and a
// saturating up-counter that bounds how long wait_in may stretch the strobe.
module as2650_wait_counter #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic run_i,
    input  logic ext_i,
    output logic done_o,
    output logic timed_out_o
);

    localparam int EXT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [3:0]       FIX_INIT = 4'(WAIT_STATES);
    localparam logic [EXT_W-1:0] EXT_MAX  = EXT_W'(TIMEOUT);

    logic [3:0]       fix_q, fix_d;
    logic [EXT_W-1:0] ext_q, ext_d;

    // Extension only starts counting once the fixed waits have been used up.
    always_comb begin
        fix_d = fix_q;
        ext_d = ext_q;
        if (load_i) begin
            fix_d = FIX_INIT;
            ext_d = '0;
        end else if (run_i) begin
            if (fix_q != 4'd0)
                fix_d = fix_q - 4'd1;
            else if (ext_i && (ext_q != EXT_MAX))
                ext_d = ext_q + EXT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fix_q <= 4'd0;
            ext_q <= '0;
        end else begin
            fix_q <= fix_d;
            ext_q <= ext_d;
        end
    end

    assign done_o      = (fix_q == 4'd0);
    assign timed_out_o = (ext_q == EXT_MAX);

endmodule

// File: rtl/as2650_extbus_ctrl.sv
// Sequences one CPU memory/IO cycle onto the multiplexed 8-bit pad bus:
// address high, address low, strobe (with fixed and external waits), hold.
module as2650_extbus_ctrl
    import as2650_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req,
    input  logic        we,
    input  logic        io_cyc,
    input  logic [14:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        err,
    input  logic [7:0]  pad_in,
    output logic [7:0]  pad_out,
    output logic [7:0]  pad_oeb,
    output logic        ale_hi,
    output logic        ale_lo,
    output logic        rd_n,
    output logic        wr_n,
    output logic        mio_n,
    input  logic        wait_in
);

    state_t     state_q;
    logic [7:0] addr_lo_q, wdata_q, rdata_q, pad_out_q, pad_oeb_q;
    logic       we_q, ack_q, err_q, ale_hi_q, ale_lo_q, rd_n_q, wr_n_q, mio_n_q;
    logic       cnt_done, cnt_tmo, strobe_exit, strobe_err;

    as2650_wait_counter #(
        .WAIT_STATES(WAIT_STATES),
        .TIMEOUT    (TIMEOUT)
    ) u_wait (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .load_i     (state_q == ADDR_L),
        .run_i      (state_q == STROBE),
        .ext_i      (wait_in),
        .done_o     (cnt_done),
        .timed_out_o(cnt_tmo)
    );

    assign strobe_exit = cnt_done && !(wait_in && !cnt_tmo);
    assign strobe_err  = cnt_done && wait_in && cnt_tmo;

    // Request operands are captured once; later input changes are ignored.
    always_ff @(posedge wb_clk_i) begin
        if (state_q == IDLE && req) begin
            addr_lo_q <= addr[7:0];
            wdata_q   <= wdata;
            we_q      <= we;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            rdata_q   <= 8'h00;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            pad_out_q <= 8'h00;
            pad_oeb_q <= OEB_FLOAT;
            ale_hi_q  <= 1'b0;
            ale_lo_q  <= 1'b0;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            mio_n_q   <= 1'b1;
        end else begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            ale_hi_q <= 1'b0;
            ale_lo_q <= 1'b0;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            // Outputs are registered: each branch sets what the next state presents.
            case (state_q)
                IDLE: begin
                    pad_out_q <= 8'h00;
                    pad_oeb_q <= OEB_FLOAT;
                    mio_n_q   <= 1'b1;
                    if (req) begin
                        state_q   <= ADDR_H;
                        pad_out_q <= {1'b0, addr[14:8]};
                        pad_oeb_q <= OEB_DRIVE;
                        ale_hi_q  <= 1'b1;
                        mio_n_q   <= ~io_cyc;
                    end
                end
                ADDR_H: begin
                    state_q   <= ADDR_L;
                    pad_out_q <= addr_lo_q;
                    pad_oeb_q <= OEB_DRIVE;
                    ale_lo_q  <= 1'b1;
                end
                ADDR_L: begin
                    state_q <= STROBE;
                    if (we_q) begin
                        wr_n_q    <= 1'b0;
                        pad_out_q <= wdata_q;
                        pad_oeb_q <= OEB_DRIVE;
                    end else begin
                        rd_n_q    <= 1'b0;
                        pad_oeb_q <= OEB_FLOAT;
                    end
                end
                STROBE: begin
                    if (strobe_exit) begin
                        state_q <= HOLD;
                        ack_q   <= 1'b1;
                        err_q   <= strobe_err;
                        if (!we_q)
                            rdata_q <= pad_in;
                    end else begin
                        rd_n_q <= we_q;
                        wr_n_q <= ~we_q;
                    end
                end
                HOLD: begin
                    state_q   <= IDLE;
                    pad_out_q <= 8'h00;
                    pad_oeb_q <= OEB_FLOAT;
                    mio_n_q   <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata   = rdata_q;
    assign ack     = ack_q;
    assign err     = err_q;
    assign pad_out = pad_out_q;
    assign pad_oeb = pad_oeb_q;
    assign ale_hi  = ale_hi_q;
    assign ale_lo  = ale_lo_q;
    assign rd_n    = rd_n_q;
    assign wr_n    = wr_n_q;
    assign mio_n   = mio_n_q;

endmodule
